pass_code_tx: RTL
=================

Name: pass_code_tx

Overview:
- Transmitter side of the button-press password interface.
- On a start request, it replays a stored passcode as a serial train of single-cycle button_1 / button_0 press pulses.
- Consecutive presses are separated by a programmable number of quiet cycles.
- Drives the password-check lock directly, both as an auto-unlock source and as a stimulus source for lock verification.

Parameters:
- CODE_LEN, 5, number of presses in the passcode; legal range 1..32.
- DEF_CODE, 5'b11010, passcode loaded when use_ext = 0; MSB is sent first; 1 = button_1, 0 = button_0.
- GAP, 2, quiet cycles (both buttons low) after every press; 0 is legal and gives back-to-back presses.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to send the code; sampled only in IDLE.
- use_ext  input  1  at start: 1 = send code_in, 0 = send DEF_CODE.
- code_in  input  CODE_LEN  external passcode, MSB first; sampled on the accepted start edge.
- button_1  output  1  one-cycle press pulse for a '1' symbol.
- button_0  output  1  one-cycle press pulse for a '0' symbol.
- busy  output  1  high from the cycle after start is accepted until done completes.
- done  output  1  one-cycle pulse marking the end of the sequence.

Behaviour:
- Clocking and reset: one clock (clk); asynchronous active-high reset (reset).
- While reset = 1: state = IDLE, shift register and counters = 0, and button_1 = button_0 = busy = done = 0.
- Reset asserted mid-sequence aborts immediately; no partial press is completed.
- All outputs are registered, with no combinational path from inputs to outputs.
- States: IDLE, PRESS, GAP_WAIT, DONE.
- IDLE:
  - Outputs low.
  - When start = 1, on that edge: latch code (code_in or DEF_CODE), load bit index = CODE_LEN-1, go to PRESS.
  - start = 0: stay in IDLE.
- PRESS, lasts exactly 1 cycle:
  - button_1 = code[idx], button_0 = ~code[idx]; exactly one of the two is high.
  - Next state: GAP_WAIT if GAP > 0, otherwise handled as the GAP_WAIT exit below.
- GAP_WAIT, lasts GAP cycles:
  - Both buttons low; gap counter counts 0..GAP-1.
  - On exit: if idx = 0 go to DONE, else decrement idx and go to PRESS.
- DONE, lasts 1 cycle: done = 1, busy = 1; then return to IDLE with busy = 0.
- busy is high in PRESS, GAP_WAIT and DONE.
- Timing:
  - Start accepted at edge E0 → first press is visible in the cycle after E0.
  - Press k (k = 0..CODE_LEN-1) occupies the cycle after edge E0 + k·(1+GAP).
  - done is high in the cycle after E0 + CODE_LEN·(1+GAP).
  - Total busy cycles = CODE_LEN·(1+GAP) + 1.
- start while busy (any state other than IDLE, including DONE) is ignored; there is no queuing.
- start must be re-asserted in IDLE to send again. A start held high continuously causes back-to-back sequences, separated by exactly 1 IDLE cycle.
- code_in and use_ext changes while busy have no effect on the sequence in flight.
- Widths:
  - idx is $clog2(CODE_LEN) bits, minimum 1.
  - Gap counter is $clog2(GAP+1) bits, minimum 1; the counter is unused when GAP = 0.
  - No wrap-around is possible: idx stops at 0.
- Illegal state encodings recover to IDLE with all outputs low.

Optional Feature:
- Macro: PASS_CODE_TX_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort = 1 in any busy state → next edge goes to IDLE with button_1 = button_0 = busy = 0 and no done pulse.
  - abort in IDLE is a no-op.
  - abort and start asserted together in IDLE: abort wins and start is ignored.
- Not defined:
  - Port is absent; a sequence always runs to completion, and only reset stops it.

Test Plan:
- Reset, then start with use_ext = 0 (GAP = 2) → presses 1,1,0,1,0 in the cycles after edges E0, E3, E6, E9, E12; done in the cycle after E15; busy high for 16 cycles; both buttons otherwise 0.
- use_ext = 1, code_in = 5'b00111; code_in changed to 5'b11111 on the edge after start → presses 0,0,1,1,1, so the latched code is used.
- Parameter override GAP = 0 with the default code → five consecutive press cycles, done in the 6th cycle; button_1 and button_0 are never high together.
- start pulsed again during GAP_WAIT and during DONE → ignored; exactly one done pulse. start held high → second sequence's first press occurs 2 cycles after the first done.
- reset asserted asynchronously between clock edges during the 3rd press → all outputs 0 immediately with no done; the next start yields a full, clean sequence.
- PASS_CODE_TX_ABORT_EN defined, abort after the 2nd press → next cycle idle, no done, busy = 0. With the macro undefined, the same stimulus completes all 5 presses.

Source files
------------

// File: rtl/pass_code_tx.sv
// pass_code_tx: replays a stored passcode as a serial train of one-cycle
// button_1 / button_0 press pulses, with GAP quiet cycles after every press.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   start     send request, sampled only in IDLE
//   use_ext   at start: 1 = send code_in, 0 = send DEF_CODE
//   code_in   external passcode, MSB first, latched on the accepted start
//   abort     (only with PASS_CODE_TX_ABORT_EN) drop the sequence in flight
//   button_1  one-cycle press pulse for a '1' symbol
//   button_0  one-cycle press pulse for a '0' symbol
//   busy      high in PRESS, GAP_WAIT and DONE
//   done      one-cycle end-of-sequence pulse
//
// Optional feature macro: PASS_CODE_TX_ABORT_EN (adds the abort input).
//
// All outputs are registered. They are decoded from the next-state values so
// that a press is visible in the cycle right after the edge that enters PRESS.
module pass_code_tx #(
    parameter int                  CODE_LEN = 5,
    parameter logic [CODE_LEN-1:0] DEF_CODE = CODE_LEN'(5'b11010),
    parameter int                  GAP      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                use_ext,
    input  logic [CODE_LEN-1:0] code_in,
`ifdef PASS_CODE_TX_ABORT_EN
    input  logic                abort,
`endif
    output logic                button_1,
    output logic                button_0,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int GW    = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0]    GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(CODE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS    = 2'd1,
        GAP_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              r_state, w_state_n;
    logic [CODE_LEN-1:0] r_code,  w_code_n;
    logic [IDX_W-1:0]    r_idx,   w_idx_n;
    logic [GW-1:0]       r_gcnt,  w_gcnt_n;
    logic                w_step;
    logic                w_b1_n, w_b0_n, w_busy_n, w_done_n;

    always_comb begin
        w_state_n = r_state;
        w_code_n  = r_code;
        w_idx_n   = r_idx;
        w_gcnt_n  = r_gcnt;
        w_step    = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_code_n  = use_ext ? code_in : DEF_CODE;
                    w_idx_n   = IDX_TOP;
                    w_gcnt_n  = '0;
                    w_state_n = PRESS;
                end
            end
            PRESS: begin
                if (GAP > 0) begin
                    w_gcnt_n  = '0;
                    w_state_n = GAP_WAIT;
                end else begin
                    w_step = 1'b1;
                end
            end
            GAP_WAIT: begin
                if (r_gcnt == GAP_LAST) w_step = 1'b1;
                else                    w_gcnt_n = r_gcnt + 1'b1;
            end
            DONE:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase

        // End of a press slot: either the last symbol went out or move on.
        if (w_step) begin
            if (r_idx == '0) begin
                w_state_n = DONE;
            end else begin
                w_idx_n   = r_idx - 1'b1;
                w_state_n = PRESS;
            end
        end

`ifdef PASS_CODE_TX_ABORT_EN
        // Also beats a simultaneous start while idle.
        if (abort) w_state_n = IDLE;
`endif

        w_b1_n   = (w_state_n == PRESS) &  w_code_n[w_idx_n];
        w_b0_n   = (w_state_n == PRESS) & ~w_code_n[w_idx_n];
        w_busy_n = (w_state_n != IDLE);
        w_done_n = (w_state_n == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_code   <= '0;
            r_idx    <= '0;
            r_gcnt   <= '0;
            button_1 <= 1'b0;
            button_0 <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_code   <= w_code_n;
            r_idx    <= w_idx_n;
            r_gcnt   <= w_gcnt_n;
            button_1 <= w_b1_n;
            button_0 <= w_b0_n;
            busy     <= w_busy_n;
            done     <= w_done_n;
        end
    end

endmodule
